// File: rtl/circular_dma_reader_fsm.sv
// Circular-buffer MM2S reader: AXI4 read bursts out of a ring buffer, streamed on AXI4-Stream.
// Optional macro CIRCULAR_DMA_READER_BURST_COUNT_EN adds the burst_count output.
//   state        | meaning
//   ST_IDLE      | waiting for a start, reports shutdown_ack
//   ST_READ_ADDR | sizing next burst, waiting for FIFO room, then AR handshake
//   ST_READ_DATA | R beats passed straight through to AXIS until rlast
module circular_dma_reader_fsm #(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_AXIS_WIDTH      = 64,
    parameter int C_MAX_BURST       = 16,
    parameter int C_FIFO_FREE_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         shutdown_req,
    output logic                         shutdown_ack,
    input  logic                         enable,
    input  logic [1:0]                   clear_irq,
    input  logic [1:0]                   enable_irq,
    output logic [1:0]                   irq,
    output logic [2:0]                   status_flags,
    input  logic [C_ADDR_WIDTH-1:0]      mem_base,
    input  logic [31:0]                  mem_size,
    input  logic [31:0]                  read_start,
    input  logic [31:0]                  read_length,
    output logic [31:0]                  bytes_read,
    output logic [31:0]                  read_offset,
    input  logic [C_FIFO_FREE_WIDTH-1:0] fifo_free,
`ifdef CIRCULAR_DMA_READER_BURST_COUNT_EN
    output logic [31:0]                  burst_count,
`endif
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [C_AXIS_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    output logic [C_AXIS_WIDTH-1:0]      m_axis_mm2s_tdata,
    output logic                         m_axis_mm2s_tlast,
    output logic                         m_axis_mm2s_tvalid,
    input  logic                         m_axis_mm2s_tready
);

    localparam int BPB           = C_AXIS_WIDTH / 8;
    localparam int LOG_BPB       = $clog2(BPB);
    localparam int C_BURST_BYTES = C_MAX_BURST * BPB;
    localparam logic [31:0] BYTE_MASK = ~32'(BPB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ_ADDR, ST_READ_DATA} state_t;
    state_t state;

    logic        err;
    logic [31:0] size_b, start_b, len_b;
    logic [31:0] room_beats, left_beats, len_beats;
    logic [31:0] burst_bytes, next_br, off_sum, next_off;
    logic        start_ok, fifo_ok, in_data, err_now, beat;

    // Sub-beat byte counts are meaningless on this bus, so they are dropped everywhere.
    assign size_b  = mem_size & BYTE_MASK;
    assign start_b = read_start & BYTE_MASK;
    assign len_b   = read_length & BYTE_MASK;

    assign room_beats = (size_b - read_offset) >> LOG_BPB;
    assign left_beats = (len_b - bytes_read) >> LOG_BPB;

    always_comb begin
        len_beats = 32'(C_MAX_BURST);
        if (room_beats < len_beats) len_beats = room_beats;
        if (left_beats < len_beats) len_beats = left_beats;
    end

    assign fifo_ok  = 32'(fifo_free) >= len_beats;
    assign start_ok = enable && (irq == 2'b00) && (len_b != 32'd0) &&
                      (size_b >= 32'(C_BURST_BYTES)) && (start_b < size_b) && !shutdown_req;

    assign burst_bytes = (32'(m_axi_arlen) + 32'd1) << LOG_BPB;
    assign next_br     = bytes_read + burst_bytes;
    assign off_sum     = read_offset + burst_bytes;
    assign next_off    = (off_sum == size_b) ? 32'd0 : off_sum;

    // The beat carrying the first error response is already treated as errored.
    assign in_data = (state == ST_READ_DATA);
    assign err_now = err | m_axi_rresp[1];
    assign beat    = in_data & m_axi_rvalid & m_axi_rready;

    assign m_axi_rready       = in_data & (err_now | m_axis_mm2s_tready);
    assign m_axis_mm2s_tvalid = in_data & m_axi_rvalid & ~err_now;
    assign m_axis_mm2s_tdata  = in_data ? m_axi_rdata : '0;
    assign m_axis_mm2s_tlast  = in_data & m_axi_rlast & ~err_now & (next_br == len_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            err           <= 1'b0;
            shutdown_ack  <= 1'b0;
            irq           <= 2'b00;
            status_flags  <= 3'b000;
            bytes_read    <= 32'd0;
            read_offset   <= 32'd0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            m_axi_arvalid <= 1'b0;
`ifdef CIRCULAR_DMA_READER_BURST_COUNT_EN
            burst_count   <= 32'd0;
`endif
        end else begin
            irq          <= irq & ~clear_irq & enable_irq;
            shutdown_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    shutdown_ack <= shutdown_req;
                    if (start_ok) begin
                        read_offset  <= start_b;
                        bytes_read   <= 32'd0;
                        status_flags <= 3'b001;
                        state        <= ST_READ_ADDR;
`ifdef CIRCULAR_DMA_READER_BURST_COUNT_EN
                        burst_count  <= 32'd0;
`endif
                    end
                end
                ST_READ_ADDR: begin
                    if (!m_axi_arvalid) begin
                        if (shutdown_req) begin
                            state           <= ST_IDLE;
                            status_flags[0] <= 1'b0;
                        end else if (fifo_ok) begin
                            m_axi_araddr  <= mem_base + C_ADDR_WIDTH'(read_offset);
                            m_axi_arlen   <= 8'(len_beats - 32'd1);
                            m_axi_arvalid <= 1'b1;
                        end
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= ST_READ_DATA;
                    end
                end
                ST_READ_DATA: begin
                    if (beat) begin
                        if (m_axi_rresp[1] && !err)
                            status_flags <= {m_axi_rresp[0], ~m_axi_rresp[0], 1'b0};
                        if (m_axi_rresp[1]) err <= 1'b1;
                        if (m_axi_rlast) begin
                            if (err_now) begin
                                state  <= ST_IDLE;
                                irq[1] <= enable_irq[1];
                                err    <= 1'b0;
                            end else begin
                                bytes_read  <= next_br;
                                read_offset <= next_off;
`ifdef CIRCULAR_DMA_READER_BURST_COUNT_EN
                                if (burst_count != '1) burst_count <= burst_count + 32'd1;
`endif
                                if (next_br == len_b || shutdown_req) begin
                                    state           <= ST_IDLE;
                                    irq[0]          <= enable_irq[0];
                                    status_flags[0] <= 1'b0;
                                end else begin
                                    state <= ST_READ_ADDR;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
